// File: rtl/ram_pkg.sv
// ram_pkg
// Definitions shared by the RAM array and its bus-side initiator:
//   - RAM_ADDR_W / RAM_DATA_W : default geometry of the 4-word x 8-bit array
//   - RW_READ / RW_WRITE      : encoding of the RAM read/write pin
//   - ram_state_t             : sequencing states of ram_initiator
package ram_pkg;

   localparam int RAM_ADDR_W = 2;
   localparam int RAM_DATA_W = 8;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      VERIFY_SETUP,
      VERIFY_ACCESS,
      RESP
   } ram_state_t;

endpackage

// File: rtl/ram_initiator_if.sv
// ram_initiator_if
// Request/response channel between a requester (datapath or test sequencer)
// and ram_initiator.
//   req_valid/req_ready : request handshake, carries req_write/req_addr/req_wdata
//   rsp_valid/rsp_ready : response handshake, carries rsp_rdata/rsp_err
// Modports:
//   master : requester side
//   slave  : ram_initiator side
interface ram_initiator_if #(
   parameter int ADDR_W = ram_pkg::RAM_ADDR_W,
   parameter int DATA_W = ram_pkg::RAM_DATA_W
);

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/ram_hold_counter.sv
// ram_hold_counter
// Loadable down-counter that times the access hold window of ram_initiator.
//   clk, rst : clock, asynchronous active-high reset
//   load     : reload the count with HOLD_CYCLES (takes priority over en)
//   en       : count down by one; the count stops at zero and never wraps
//   done     : high during the last cycle of a loaded hold window
module ram_hold_counter #(
   parameter  int HOLD_CYCLES = 1,
   localparam int CW          = $clog2(HOLD_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic done
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(HOLD_CYCLES);
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   // The count is HOLD_CYCLES in the first hold cycle, so a value of one
   // marks the final hold cycle.
   assign done = (cnt == CW'(1));

endmodule

// File: rtl/ram_initiator.sv
// ram_initiator
// Bus-side initiator for the binary-cell RAM. Accepts one read or write
// request at a time, sequences the RAM select/read-write/data pins with a
// HOLD_CYCLES access window, captures read data and returns one response.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : request/response channel (ram_initiator_if.slave)
//   mem_sel    : RAM word select (bit 0 -> s0, bit 1 -> s1)
//   mem_rw     : RAM read/write, 1 = write strobe
//   mem_wdata  : RAM write data
//   mem_rdata  : RAM read data, combinational from the array
// Configuration:
//   RAM_INITIATOR_VERIFY_EN : when defined, every write is followed by a
//   readback; the response carries the readback value and a mismatch flag.
//   When undefined, write responses carry rsp_rdata = 0 and rsp_err = 0.
module ram_initiator
   import ram_pkg::*;
#(
   parameter int ADDR_W      = RAM_ADDR_W,
   parameter int DATA_W      = RAM_DATA_W,
   parameter int HOLD_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   ram_initiator_if.slave      bus,
   output logic [ADDR_W-1:0]   mem_sel,
   output logic                mem_rw,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   ram_state_t        state;
   logic              wr_q;
   logic              req_ready_r;
   logic              rsp_valid_r;
   logic              rsp_err_r;
   logic [DATA_W-1:0] rsp_rdata_r;

   logic hold_load;
   logic hold_en;
   logic hold_done;

   // The counter is loaded while in a setup state so that it holds
   // HOLD_CYCLES on the first access cycle.
   assign hold_load = (state == SETUP) || (state == VERIFY_SETUP);
   assign hold_en   = (state == ACCESS) || (state == VERIFY_ACCESS);

   ram_hold_counter #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold (
      .clk  (clk),
      .rst  (rst),
      .load (hold_load),
      .en   (hold_en),
      .done (hold_done)
   );

   assign bus.req_ready = req_ready_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_err   = rsp_err_r;
   assign bus.rsp_rdata = rsp_rdata_r;

   // mem_sel and mem_wdata are written only on request acceptance, so they
   // stay stable for the whole access and hold their value while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wr_q        <= RW_READ;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= '0;
         mem_sel     <= '0;
         mem_rw      <= RW_READ;
         mem_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  wr_q        <= bus.req_write;
                  mem_sel     <= bus.req_addr;
                  mem_wdata   <= bus.req_wdata;
                  req_ready_r <= 1'b0;
                  state       <= SETUP;
               end
            end

            SETUP: begin
               mem_rw <= wr_q;
               state  <= ACCESS;
            end

            ACCESS: begin
               if (hold_done) begin
                  mem_rw <= RW_READ;
                  if (wr_q == RW_WRITE) begin
`ifdef RAM_INITIATOR_VERIFY_EN
                     state <= VERIFY_SETUP;
`else
                     rsp_rdata_r <= '0;
                     rsp_err_r   <= 1'b0;
                     rsp_valid_r <= 1'b1;
                     state       <= RESP;
`endif
                  end else begin
                     rsp_rdata_r <= mem_rdata;
                     rsp_err_r   <= 1'b0;
                     rsp_valid_r <= 1'b1;
                     state       <= RESP;
                  end
               end
            end

`ifdef RAM_INITIATOR_VERIFY_EN
            VERIFY_SETUP: begin
               state <= VERIFY_ACCESS;
            end

            VERIFY_ACCESS: begin
               if (hold_done) begin
                  rsp_rdata_r <= mem_rdata;
                  rsp_err_r   <= (mem_rdata != mem_wdata);
                  rsp_valid_r <= 1'b1;
                  state       <= RESP;
               end
            end
`endif

            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  req_ready_r <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_initiator.sv
// tb_ram_initiator
// Bench for ram_initiator: two instances (HOLD_CYCLES = 1 and 3), each with
// its own RAM array model. A cycle-level expectation model derived from the
// access timeline (setup, hold window, response) is compared against both
// instances on every falling edge; directed scenarios add literal checks.
// Honours RAM_INITIATOR_VERIFY_EN in the same way as the design.
module tb_ram_initiator;

   localparam int H0 = 1;
   localparam int H1 = 3;
`ifdef RAM_INITIATOR_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- stimulus / observation arrays ----------------
   logic       rq_valid [2];
   logic       rq_write [2];
   logic [1:0] rq_addr  [2];
   logic [7:0] rq_wdata [2];
   logic       rs_ready [2];
   logic       o_rr [2];
   logic       o_rv [2];
   logic       o_re [2];
   logic [7:0] o_rd [2];
   logic [1:0] msel [2];
   logic       mrw  [2];
   logic [7:0] mwd  [2];
   logic [7:0] mrd  [2];
   logic [7:0] ram  [2][4];
   logic [7:0] mask;
   int         rwc  [2];

   ram_initiator_if #(.ADDR_W(2), .DATA_W(8)) if0 ();
   ram_initiator_if #(.ADDR_W(2), .DATA_W(8)) if1 ();

   assign if0.req_valid = rq_valid[0];
   assign if0.req_write = rq_write[0];
   assign if0.req_addr  = rq_addr[0];
   assign if0.req_wdata = rq_wdata[0];
   assign if0.rsp_ready = rs_ready[0];
   assign if1.req_valid = rq_valid[1];
   assign if1.req_write = rq_write[1];
   assign if1.req_addr  = rq_addr[1];
   assign if1.req_wdata = rq_wdata[1];
   assign if1.rsp_ready = rs_ready[1];
   assign o_rr[0] = if0.req_ready;
   assign o_rv[0] = if0.rsp_valid;
   assign o_re[0] = if0.rsp_err;
   assign o_rd[0] = if0.rsp_rdata;
   assign o_rr[1] = if1.req_ready;
   assign o_rv[1] = if1.rsp_valid;
   assign o_re[1] = if1.rsp_err;
   assign o_rd[1] = if1.rsp_rdata;

   ram_initiator #(.ADDR_W(2), .DATA_W(8), .HOLD_CYCLES(H0)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (if0),
      .mem_sel   (msel[0]),
      .mem_rw    (mrw[0]),
      .mem_wdata (mwd[0]),
      .mem_rdata (mrd[0])
   );

   ram_initiator #(.ADDR_W(2), .DATA_W(8), .HOLD_CYCLES(H1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .bus       (if1),
      .mem_sel   (msel[1]),
      .mem_rw    (mrw[1]),
      .mem_wdata (mwd[1]),
      .mem_rdata (mrd[1])
   );

   // RAM arrays: combinational read (optionally with stuck bits), write on
   // a clock edge while the write strobe is high.
   always_comb begin
      for (int d = 0; d < 2; d++) mrd[d] = ram[d][msel[d]] & mask;
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++)
         if (mrw[d]) ram[d][msel[d]] <= mwd[d];
   end

   // ---------------- expectation model ----------------
   // e counts edges since acceptance: e=0 setup cycle, e=1..H hold window,
   // response from e=lat until the handshake.
   bit         busy [2];
   int         e    [2];
   int         lat  [2];
   logic       wr_m [2];
   logic [1:0] ad_m [2];
   logic [7:0] wd_m [2];
   logic [7:0] xr   [2];
   logic       xe   [2];
   logic [7:0] mdl  [2][4];

   function automatic int hold_of(input int d);
      return (d == 0) ? H0 : H1;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            busy[d] <= 1'b0;
         end else if (!busy[d]) begin
            if (rq_valid[d]) begin
               busy[d] <= 1'b1;
               e[d]    <= 0;
               wr_m[d] <= rq_write[d];
               ad_m[d] <= rq_addr[d];
               wd_m[d] <= rq_wdata[d];
               if (rq_write[d]) begin
                  mdl[d][rq_addr[d]] <= rq_wdata[d];
                  lat[d] <= VER ? 2 * (hold_of(d) + 1) : hold_of(d) + 1;
                  xr[d]  <= VER ? (rq_wdata[d] & mask) : 8'h00;
                  xe[d]  <= VER && ((rq_wdata[d] & mask) != rq_wdata[d]);
               end else begin
                  lat[d] <= hold_of(d) + 1;
                  xr[d]  <= mdl[d][rq_addr[d]] & mask;
                  xe[d]  <= 1'b0;
               end
            end
         end else if ((e[d] >= lat[d]) && rs_ready[d]) begin
            busy[d] <= 1'b0;
         end else begin
            e[d] <= e[d] + 1;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int d, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d got=%0h want=%0h", nm, d, act, exp);
      end
   endtask

   // Advance to the next falling edge and compare both instances against
   // the model.
   task automatic tick();
      @(negedge clk);
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            bit rv_x;
            rv_x = busy[d] && (e[d] >= lat[d]);
            chk("req_ready", d, 32'(o_rr[d]), 32'(!busy[d]));
            chk("rsp_valid", d, 32'(o_rv[d]), 32'(rv_x));
            chk("mem_rw", d, 32'(mrw[d]),
                32'(busy[d] && wr_m[d] && (e[d] >= 1) && (e[d] <= hold_of(d))));
            if (busy[d]) begin
               chk("mem_sel", d, 32'(msel[d]), 32'(ad_m[d]));
               chk("mem_wdata", d, 32'(mwd[d]), 32'(wd_m[d]));
            end
            if (rv_x) begin
               chk("rsp_rdata", d, 32'(o_rd[d]), 32'(xr[d]));
               chk("rsp_err", d, 32'(o_re[d]), 32'(xe[d]));
            end
            if (mrw[d]) rwc[d]++;
         end
      end
   endtask

   // One complete transaction; called at a falling edge. hold_lo > 0 keeps
   // rsp_ready low that many cycles after rsp_valid appears and meanwhile
   // presents a second request that must be ignored.
   task automatic do_req(input int d, input logic w, input logic [1:0] a,
                         input logic [7:0] wd, input int hold_lo,
                         output logic [7:0] rd, output logic er, output int lt);
      int n;
      n = 0;
      rq_valid[d] = 1'b1;
      rq_write[d] = w;
      rq_addr[d]  = a;
      rq_wdata[d] = wd;
      rs_ready[d] = (hold_lo == 0);
      while (!o_rr[d] && n < 50) begin
         tick();
         n++;
      end
      chk("accept_in_time", d, 32'(n < 50), 32'd1);
      tick();
      rq_valid[d] = 1'b0;
      lt = 0;
      while (!o_rv[d] && lt < 50) begin
         tick();
         lt++;
      end
      chk("rsp_in_time", d, 32'(lt < 50), 32'd1);
      for (int i = 0; i < hold_lo; i++) begin
         rq_valid[d] = 1'b1;
         rq_write[d] = 1'b1;
         rq_addr[d]  = 2'd0;
         rq_wdata[d] = 8'hEE;
         tick();
      end
      rq_valid[d] = 1'b0;
      rd = o_rd[d];
      er = o_re[d];
      rs_ready[d] = 1'b1;
      tick();
      rs_ready[d] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [7:0] rd;
      logic       er;
      int         lt;
      int         c0;
      logic [7:0] tbl [4];
      tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst  = 1'b1;
      mask = 8'hFF;
      for (int d = 0; d < 2; d++) begin
         rq_valid[d] = 1'b0;
         rq_write[d] = 1'b0;
         rq_addr[d]  = 2'd0;
         rq_wdata[d] = 8'h00;
         rs_ready[d] = 1'b0;
      end
      tick();
      tick();
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", d, 32'(o_rr[d]), 32'd1);
         chk("rst_rsp_valid", d, 32'(o_rv[d]), 32'd0);
         chk("rst_rsp_err", d, 32'(o_re[d]), 32'd0);
         chk("rst_rsp_rdata", d, 32'(o_rd[d]), 32'd0);
         chk("rst_mem_sel", d, 32'(msel[d]), 32'd0);
         chk("rst_mem_rw", d, 32'(mrw[d]), 32'd0);
         chk("rst_mem_wdata", d, 32'(mwd[d]), 32'd0);
      end
      rst = 1'b0;
      tick();

      // write 0xA5 to addr 2, then read it back (HOLD_CYCLES=1)
      c0 = rwc[0];
      do_req(0, 1'b1, 2'd2, 8'hA5, 0, rd, er, lt);
      chk("wr_latency", 0, 32'(lt), VER ? 32'd4 : 32'd2);
      chk("wr_rdata", 0, 32'(rd), VER ? 32'hA5 : 32'h00);
      chk("wr_err", 0, 32'(er), 32'd0);
      chk("wr_strobe_cycles", 0, 32'(rwc[0] - c0), 32'd1);
      do_req(0, 1'b0, 2'd2, 8'h00, 0, rd, er, lt);
      chk("rd_latency", 0, 32'(lt), 32'd2);
      chk("rd_a5", 0, 32'(rd), 32'hA5);

      // fill all four words, then read them back
      for (int i = 0; i < 4; i++) do_req(0, 1'b1, 2'(i), tbl[i], 0, rd, er, lt);
      for (int i = 0; i < 4; i++) begin
         do_req(0, 1'b0, 2'(i), 8'h00, 0, rd, er, lt);
         chk("rd_table", i, 32'(rd), 32'(tbl[i]));
      end

      // HOLD_CYCLES=3: write, then read with a stalled consumer
      c0 = rwc[1];
      do_req(1, 1'b1, 2'd1, 8'h3C, 0, rd, er, lt);
      chk("h3_wr_latency", 1, 32'(lt), VER ? 32'd8 : 32'd4);
      chk("h3_strobe_cycles", 1, 32'(rwc[1] - c0), 32'd3);
      do_req(1, 1'b0, 2'd1, 8'h00, 5, rd, er, lt);
      chk("h3_rd_latency", 1, 32'(lt), 32'd4);
      chk("h3_rd_stalled", 1, 32'(rd), 32'h3C);
      do_req(1, 1'b1, 2'd0, 8'h77, 0, rd, er, lt);
      do_req(1, 1'b0, 2'd0, 8'h00, 0, rd, er, lt);
      chk("h3_rd_addr0", 1, 32'(rd), 32'h77);

      // reset during a write hold window to addr 3
      rq_valid[1] = 1'b1;
      rq_write[1] = 1'b1;
      rq_addr[1]  = 2'd3;
      rq_wdata[1] = 8'h5A;
      rs_ready[1] = 1'b1;
      tick();
      rq_valid[1] = 1'b0;
      tick();
      chk("rw_before_rst", 1, 32'(mrw[1]), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rw_async_drop", 1, 32'(mrw[1]), 32'd0);
      chk("rst_ready_mid", 1, 32'(o_rr[1]), 32'd1);
      chk("rst_no_rsp_mid", 1, 32'(o_rv[1]), 32'd0);
      tick();
      rst = 1'b0;
      rs_ready[1] = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("no_rsp_after_rst", 1, 32'(o_rv[1]), 32'd0);
      do_req(1, 1'b0, 2'd1, 8'h00, 0, rd, er, lt);
      chk("rd_after_rst", 1, 32'(rd), 32'h3C);

`ifdef RAM_INITIATOR_VERIFY_EN
      // readback with data bit 3 stuck at 0
      mask = 8'hF7;
      do_req(0, 1'b1, 2'd1, 8'h08, 0, rd, er, lt);
      chk("vfy_08_rdata", 0, 32'(rd), 32'h00);
      chk("vfy_08_err", 0, 32'(er), 32'd1);
      do_req(0, 1'b1, 2'd1, 8'hF0, 0, rd, er, lt);
      chk("vfy_f0_rdata", 0, 32'(rd), 32'hF0);
      chk("vfy_f0_err", 0, 32'(er), 32'd0);
      mask = 8'hFF;
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
